uo_bus_arbiter: RTL and testbench
=================================

// Module: uo_bus_arbiter
// PURPOSE
//   Round-robin arbiter that shares the 8-bit dedicated output bus (uo_out) of the
//   tt_um_chandrakanth_simple_circuit top level among N internal requesters.
//   Grants one requester at a time for a bounded burst, registers the winner's
//   data onto the bus, and rotates priority so that no requester starves.
//   Sits between the datapath sub-blocks and the uo_out pin driver.
// PARAMETERS
//   N_REQ      4   number of requesters (2..8)
//   DATA_W     8   data width per requester, equals the bus width
//   MAX_BURST  4   max accepted beats per grant (1..15)
// PORTS
//   clk        in   1               system clock, rising edge
//   rst_n      in   1               asynchronous reset, active low
//   ena        in   1               design selected; 0 = stop granting
//   req        in   N_REQ           request bit per requester, held while data valid
//   data       in   N_REQ*DATA_W    flattened data, requester i at [i*DATA_W +: DATA_W]
//   last       in   N_REQ           final beat of the requester's burst, qualified by req
//   gnt        out  N_REQ           one-hot grant (or all zero), registered
//   bus_data   out  DATA_W          registered bus data -> uo_out
//   bus_valid  out  1               bus_data holds a beat accepted in the previous cycle
//   bus_owner  out  $clog2(N_REQ)   index of the requester that produced bus_data
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, gnt=0, bus_valid=0, bus_data=0, bus_owner=0,
//     rr_ptr=0, beat_cnt=0. Release is synchronous to clk.
//   States: IDLE, GRANT.
//   IDLE: if ena & |req -> winner = first i with req[i], scanning rr_ptr, rr_ptr+1, ...
//     modulo N_REQ. gnt[winner]<=1, owner<=winner, beat_cnt<=0, state<=GRANT.
//     Otherwise stay in IDLE, gnt=0.
//   GRANT, each cycle (owner = o):
//     beat = gnt[o] & req[o] & ena. On a beat: bus_data<=data[o], bus_owner<=o,
//       bus_valid<=1, beat_cnt<=beat_cnt+1. With no beat: bus_valid<=0, bus_data is held.
//     The burst ends when (beat & last[o]) | (beat & beat_cnt==MAX_BURST-1) | !req[o] | !ena.
//     At burst end: gnt<=0, rr_ptr<=(o+1) mod N_REQ, state<=IDLE.
//   Latency: req seen in IDLE at cycle t -> gnt at t+1 -> first beat accepted at edge
//     ending t+1 -> bus_valid/bus_data visible at t+2. One dead cycle (IDLE) between grants.
//   Throughput: 1 beat/cycle during a grant; max MAX_BURST consecutive beats.
//   Simultaneous events: last on beat MAX_BURST is treated as a single burst end.
//     Requests from other requesters during GRANT are ignored until IDLE.
//   Non-owner req/data/last are don't-care. gnt is never asserted for more than one bit.
//   req dropping mid-burst: no beat that cycle, burst ends, rr_ptr advances.
//   ena low mid-burst: no beat that cycle, burst ends, no new grant while ena=0.
//   Reset mid-burst: all outputs take their reset values immediately; no partial beat
//     is reported.
//   beat_cnt width: $clog2(MAX_BURST+1); it never wraps because of the burst-end rule.
// TESTING
//   1 Reset: rst_n=0 with req=4'hF -> gnt=0, bus_valid=0, bus_data=8'h00, bus_owner=0.
//   2 Single request: req=4'b0100, data[2]=8'hA5, last[2]=1 in the grant cycle -> gnt=4'b0100
//     one cycle after req; bus_data=8'hA5, bus_owner=2, bus_valid=1 one cycle later;
//     then gnt=0.
//   3 Round robin: req=4'hF held, last=4'hF -> grant order 0,1,2,3,0 with one IDLE cycle
//     between grants.
//   4 Burst cap: req[1]=1, last[1]=0 held, data 8'h10..8'h15 -> exactly 4 beats
//     8'h10..8'h13, then gnt drops and rr_ptr=2.
//   5 Abort: ena dropped after 2 beats of owner 3 -> bus_valid=0 the next cycle, gnt=0,
//     and no grant while ena=0; with ena=1 again and req=4'b1001, requester 0 wins.
//   6 Async reset mid-burst: assert rst_n=0 between clock edges -> gnt and bus_valid
//     go to 0 without waiting for a clock edge; after release, req=4'b0010 is granted
//     from rr_ptr=0 (requester 1).

Source files
------------

// File: rtl/uo_bus_arbiter.sv
// uo_bus_arbiter: round-robin arbiter sharing the uo_out bus among N_REQ requesters,
// granting bounded bursts and registering the winning beat onto the bus.
module uo_bus_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  input  logic [N_REQ-1:0]          last_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [DATA_W-1:0]         bus_data_o,
  output logic                      bus_valid_o,
  output logic [$clog2(N_REQ)-1:0]  bus_owner_o
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [PTR_W-1:0]   owner_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic [DATA_W-1:0]  bus_data_q;
  logic               bus_valid_q;
  logic [PTR_W-1:0]   bus_owner_q;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [DATA_W-1:0]  own_data;
  logic               own_req;
  logic               own_last;
  logic               beat;
  logic               burst_end;
  // Scan from the farthest candidate back to rr_ptr so the nearest requester is written last.
  always_comb begin
    cand    = '0;
    win_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (req_i[cand]) win_idx = cand;
    end
  end
  always_comb begin
    own_data  = data_i[int'(owner_q)*DATA_W +: DATA_W];
    own_req   = req_i[owner_q];
    own_last  = last_i[owner_q];
    beat      = (state_q == GRANT) && gnt_q[owner_q] && own_req && ena_i;
    burst_end = (beat && (own_last || beat_cnt_q == CNT_W'(MAX_BURST - 1))) || !own_req || !ena_i;
    next_ptr  = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
      bus_owner_q <= '0;
    end else if (state_q == IDLE) begin
      bus_valid_q <= 1'b0;
      if (ena_i && |req_i) begin
        gnt_q      <= N_REQ'(1) << win_idx;
        owner_q    <= win_idx;
        beat_cnt_q <= '0;
        state_q    <= GRANT;
      end
    end else begin
      bus_valid_q <= beat;
      if (beat) begin
        bus_data_q  <= own_data;
        bus_owner_q <= owner_q;
        beat_cnt_q  <= beat_cnt_q + 1'b1;
      end
      if (burst_end) begin
        gnt_q    <= '0;
        rr_ptr_q <= next_ptr;
        state_q  <= IDLE;
      end
    end
  end
  assign gnt_o       = gnt_q;
  assign bus_data_o  = bus_data_q;
  assign bus_valid_o = bus_valid_q;
  assign bus_owner_o = bus_owner_q;
endmodule

// File: tb/tb_uo_bus_arbiter.sv
// tb_uo_bus_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model of the round-robin burst arbiter.
module tb_uo_bus_arbiter;
  localparam int N = 4, W = 8, MB = 4;
  logic        clk = 0, rst_n = 0, ena = 0;
  logic [3:0]  req = '0, last = '0;
  logic [31:0] data = '0;
  logic [3:0]  gnt;
  logic [7:0]  bus_data;
  logic        bus_valid;
  logic [1:0]  bus_owner;
  int checks = 0, errors = 0;
  int m_owner = -1, m_ptr = 0, m_beats = 0, m_bus_owner = 0;
  logic [7:0] m_bus_data = '0;
  bit m_valid = 0;

  uo_bus_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .ena_i(ena), .req_i(req), .data_i(data), .last_i(last),
    .gnt_o(gnt), .bus_data_o(bus_data), .bus_valid_o(bus_valid), .bus_owner_o(bus_owner)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_gnt();
    return (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
  endfunction

  task automatic m_reset();
    m_owner = -1; m_ptr = 0; m_beats = 0; m_bus_owner = 0; m_bus_data = '0; m_valid = 0;
  endtask

  // One clock: the model consumes the inputs seen before the edge, outputs are sampled 1ns after.
  task automatic tick();
    logic [3:0] r, l;
    logic [31:0] d;
    logic e;
    int o;
    bit done;
    r = req; l = last; d = data; e = ena;
    @(posedge clk); #1;
    if (m_owner < 0) begin
      m_valid = 0;
      if (e && r != 0) begin
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_beats = 0;
      end
    end else begin
      o = m_owner;
      m_valid = r[o] && e;
      done = !m_valid;
      if (m_valid) begin
        m_bus_data = d[o*8 +: 8];
        m_bus_owner = o;
        m_beats++;
        done = l[o] || (m_beats == MB);
      end
      if (done) begin
        m_ptr = (o + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic flush();
    req = '0; last = '0; ena = 1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 0; req = 4'hF; ena = 1;
    m_reset();
    @(negedge clk);
    checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt got %h want 0", gnt); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus_valid); end
    checks++; if (bus_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus_data); end
    checks++; if (bus_owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", bus_owner); end
    @(posedge clk); #1;
    checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL reset_hold_gnt got %h want 0", gnt); end
    rst_n = 1; req = '0;
  endtask

  task automatic test_single();
    req = 4'b0100; data = '0; data[23:16] = 8'hA5; last = 4'b0100; ena = 1;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want 0100", gnt); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", bus_valid); end
    tick();
    checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus_valid); end
    checks++; if (bus_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", bus_data); end
    checks++; if (bus_owner !== 2'd2) begin errors++; $display("FAIL single_owner got %0d want 2", bus_owner); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_drop got %b want 0000", gnt); end
    req = '0;
    tick();
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b want 0", bus_valid); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d;
    rst_n = 0; #2; rst_n = 1;
    m_reset();
    req = 4'hF; last = 4'hF; ena = 1;
    for (int i = 0; i < 5; i++) begin
      data = $urandom;
      exp_d = data[(i % 4)*8 +: 8];
      tick();
      checks++; if (gnt !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_gnt[%0d] got %b want %b", i, gnt, 4'(1 << (i % 4))); end
      tick();
      checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL rr_dead_cycle[%0d] got %b want 0000", i, gnt); end
      checks++; if (bus_valid !== 1'b1 || bus_owner !== 2'(i % 4) || bus_data !== exp_d) begin
        errors++; $display("FAIL rr_beat[%0d] got v=%b o=%0d d=%h want v=1 o=%0d d=%h", i, bus_valid, bus_owner, bus_data, i % 4, exp_d);
      end
    end
  endtask

  task automatic test_burst_cap();
    flush();
    req = 4'b0010; last = '0; data = '0; data[15:8] = 8'h10;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL cap_gnt got %b want 0010", gnt); end
    for (int b = 0; b < 4; b++) begin
      tick();
      checks++; if (bus_valid !== 1'b1 || bus_data !== 8'(8'h10 + b)) begin
        errors++; $display("FAIL cap_beat[%0d] got v=%b d=%h want v=1 d=%h", b, bus_valid, bus_data, 8'(8'h10 + b));
      end
      checks++; if (gnt !== ((b == 3) ? 4'b0000 : 4'b0010)) begin errors++; $display("FAIL cap_gnt[%0d] got %b", b, gnt); end
      data[15:8] = 8'(8'h11 + b);
    end
    req = 4'b0110;
    tick();
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL cap_no_fifth got %b want 0", bus_valid); end
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL cap_rr_ptr got %b want 0100", gnt); end
  endtask

  task automatic test_abort();
    flush();
    req = 4'b1000; last = '0; data = 32'h77000000;
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL abort_gnt got %b want 1000", gnt); end
    repeat (2) tick();
    checks++; if (bus_valid !== 1'b1 || bus_owner !== 2'd3) begin errors++; $display("FAIL abort_beats got v=%b o=%0d want v=1 o=3", bus_valid, bus_owner); end
    ena = 0; req = 4'hF;
    tick();
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", bus_valid); end
    checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL abort_gnt_drop got %b want 0", gnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL abort_hold[%0d] got %b want 0", i, gnt); end
    end
    ena = 1; req = 4'b1001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL abort_resume got %b want 0001", gnt); end
  endtask

  task automatic test_async_reset();
    flush();
    req = 4'b0100; last = '0; data = 32'h00330000;
    repeat (2) tick();
    checks++; if (bus_valid !== 1'b1 || gnt !== 4'b0100) begin errors++; $display("FAIL areset_pre got v=%b g=%b want v=1 g=0100", bus_valid, gnt); end
    #2 rst_n = 0;
    #1;
    checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL areset_gnt got %b want 0", gnt); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", bus_valid); end
    m_reset();
    #1 rst_n = 1;
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL areset_regrant got %b want 0010", gnt); end
  endtask

  task automatic test_random();
    flush();
    for (int i = 0; i < 600; i++) begin
      ena  = ($urandom_range(0, 9) != 0);
      req  = 4'($urandom);
      last = 4'($urandom) & 4'($urandom);
      data = $urandom;
      tick();
      checks++; if (gnt !== m_gnt()) begin errors++; $display("FAIL rand_gnt[%0d] got %b want %b", i, gnt, m_gnt()); end
      checks++; if (bus_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d] got %b want %b", i, bus_valid, m_valid); end
      checks++; if (bus_data !== m_bus_data) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", i, bus_data, m_bus_data); end
      checks++; if (bus_owner !== 2'(m_bus_owner)) begin errors++; $display("FAIL rand_owner[%0d] got %0d want %0d", i, bus_owner, m_bus_owner); end
      checks++; if ($countones(gnt) > 1) begin errors++; $display("FAIL rand_onehot[%0d] got %b want at most one bit", i, gnt); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
